// File: rtl/ctr_drbg_core.sv
// ctr_drbg_core: CTR_DRBG state machine for AES-128 with a 128-bit counter.
//
// The core holds the DRBG working state (Key, V, reseed counter) and runs
// Instantiate, Reseed and Generate. It has no prediction resistance and takes
// no additional input. Block encryptions are done by an external AES-128 ECB
// engine that is reached over a request/acknowledge port.
//
// Ports
//   clk             clock
//   rst             synchronous active-high reset
//   cmd_valid_i     command strobe, taken only while cmd_ready_o is high
//   cmd_i           00 NOP, 01 INSTANTIATE, 10 RESEED, 11 GENERATE
//   seed_i          256-bit seed material (MSB-first), used by INSTANTIATE/RESEED
//   nblocks_i       number of 128-bit blocks a GENERATE produces
//   cmd_ready_o     high only while idle
//   aes_req_o       encryption request, held until aes_ack_i
//   aes_key_o       current Key
//   aes_pt_o        plaintext, which is V after its increment
//   aes_ack_i       one-cycle acknowledge; aes_ct_i is valid in the same cycle
//   aes_ct_i        ciphertext
//   rnd_valid_o     random block valid
//   rnd_o           random block, MSB-first
//   rnd_ready_i     downstream accept; a block transfers when valid and ready are both high
//   done_o          one-cycle pulse when a command completes
//   err_o           one-cycle pulse, together with done_o, when a command is rejected
//   instantiated_o  the working state is valid
//   reseed_req_o    the reseed counter has passed RESEED_INTERVAL

module ctr_drbg_core #(
  parameter int unsigned SEED_BITS       = 256,
  parameter int unsigned MAX_BLOCKS      = 64,
  parameter int unsigned RESEED_INTERVAL = 32'h1000,
  localparam int unsigned NbW            = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid_i,
  input  logic [1:0]           cmd_i,
  input  logic [SEED_BITS-1:0] seed_i,
  input  logic [NbW-1:0]       nblocks_i,
  output logic                 cmd_ready_o,
  output logic                 aes_req_o,
  output logic [127:0]         aes_key_o,
  output logic [127:0]         aes_pt_o,
  input  logic                 aes_ack_i,
  input  logic [127:0]         aes_ct_i,
  output logic                 rnd_valid_o,
  output logic [127:0]         rnd_o,
  input  logic                 rnd_ready_i,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 instantiated_o,
  output logic                 reseed_req_o
);

  localparam logic [1:0] CmdInst   = 2'b01;
  localparam logic [1:0] CmdReseed = 2'b10;
  localparam logic [1:0] CmdGen    = 2'b11;

  localparam logic [NbW-1:0] MaxBlk  = NbW'(MAX_BLOCKS);
  localparam logic [NbW-1:0] OneBlk  = NbW'(1);
  localparam logic [31:0]    Interval = 32'(RESEED_INTERVAL);

  typedef enum logic [2:0] {
    StIdle,
    StUpd0,
    StUpd1,
    StUpdApply,
    StGenEnc,
    StGenOut,
    StDone
  } state_e;

  // Which command the shared Update sequence is finishing.
  typedef enum logic [1:0] {
    OpInst,
    OpReseed,
    OpGen
  } op_e;

  state_e               r_state;
  op_e                  r_op;
  logic [127:0]         r_key;
  logic [127:0]         r_v;
  logic [SEED_BITS-1:0] r_pd;
  logic [SEED_BITS-1:0] r_t;
  logic [31:0]          r_ctr;
  logic [NbW-1:0]       r_blk;
  logic                 r_inst;
  logic                 r_aes_req;
  logic [127:0]         r_rnd;
  logic                 r_rnd_valid;
  logic                 r_done;
  logic                 r_err;

  logic w_reseed_req;
  logic w_gen_bad;

  assign w_reseed_req = (r_ctr > Interval);

  // Any of these conditions makes a GENERATE fail without touching the working state.
  assign w_gen_bad = !r_inst || w_reseed_req || (nblocks_i == '0) || (nblocks_i > MaxBlk);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_op        <= OpInst;
      r_key       <= '0;
      r_v         <= '0;
      r_pd        <= '0;
      r_t         <= '0;
      r_ctr       <= '0;
      r_blk       <= '0;
      r_inst      <= 1'b0;
      r_aes_req   <= 1'b0;
      r_rnd       <= '0;
      r_rnd_valid <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (cmd_valid_i) begin
            case (cmd_i)
              CmdInst: begin
                r_key   <= '0;
                r_v     <= '0;
                r_pd    <= seed_i;
                r_op    <= OpInst;
                r_state <= StUpd0;
              end
              CmdReseed: begin
                if (!r_inst) begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= StDone;
                end else begin
                  r_pd    <= seed_i;
                  r_op    <= OpReseed;
                  r_state <= StUpd0;
                end
              end
              CmdGen: begin
                if (w_gen_bad) begin
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= StDone;
                end else begin
                  r_blk   <= nblocks_i;
                  r_op    <= OpGen;
                  r_state <= StGenEnc;
                end
              end
              default: ; // NOP
            endcase
          end
        end

        // Each encryption state first bumps V and raises the request in the
        // same edge, then waits for the acknowledge. Key and V stay put while
        // the request is pending, so the engine sees a stable key/plaintext.
        StUpd0: begin
          if (!r_aes_req) begin
            r_v       <= r_v + 128'd1;
            r_aes_req <= 1'b1;
          end else if (aes_ack_i) begin
            r_aes_req                 <= 1'b0;
            r_t[SEED_BITS-1 -: 128]   <= aes_ct_i;
            r_state                   <= StUpd1;
          end
        end

        StUpd1: begin
          if (!r_aes_req) begin
            r_v       <= r_v + 128'd1;
            r_aes_req <= 1'b1;
          end else if (aes_ack_i) begin
            r_aes_req   <= 1'b0;
            r_t[127:0]  <= aes_ct_i;
            r_state     <= StUpdApply;
          end
        end

        StUpdApply: begin
          r_key <= r_t[SEED_BITS-1 -: 128] ^ r_pd[SEED_BITS-1 -: 128];
          r_v   <= r_t[127:0] ^ r_pd[127:0];
          case (r_op)
            OpInst: begin
              r_ctr  <= 32'd1;
              r_inst <= 1'b1;
            end
            OpReseed: r_ctr <= 32'd1;
            default: begin
              if (r_ctr != '1) begin
                r_ctr <= r_ctr + 32'd1;
              end
            end
          endcase
          r_done  <= 1'b1;
          r_state <= StDone;
        end

        StGenEnc: begin
          if (!r_aes_req) begin
            r_v       <= r_v + 128'd1;
            r_aes_req <= 1'b1;
          end else if (aes_ack_i) begin
            r_aes_req   <= 1'b0;
            r_rnd       <= aes_ct_i;
            r_rnd_valid <= 1'b1;
            r_state     <= StGenOut;
          end
        end

        StGenOut: begin
          if (rnd_ready_i) begin
            r_rnd_valid <= 1'b0;
            r_blk       <= r_blk - OneBlk;
            if (r_blk == OneBlk) begin
              // Last block handed over: refresh Key/V with an all-zero Update.
              r_pd    <= '0;
              r_state <= StUpd0;
            end else begin
              r_state <= StGenEnc;
            end
          end
        end

        StDone: begin
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_state <= StIdle;
        end

        default: r_state <= StIdle;
      endcase
    end
  end

  assign cmd_ready_o    = (r_state == StIdle);
  assign aes_req_o      = r_aes_req;
  assign aes_key_o      = r_key;
  assign aes_pt_o       = r_v;
  assign rnd_valid_o    = r_rnd_valid;
  assign rnd_o          = r_rnd;
  assign done_o         = r_done;
  assign err_o          = r_err;
  assign instantiated_o = r_inst;
  assign reseed_req_o   = w_reseed_req;

endmodule

// File: tb/tb_ctr_drbg_core.sv
// Directed bench for ctr_drbg_core. The AES engine is stood in for by a keyed
// mixing function; a small CTR_DRBG model built on that same function predicts
// Key, V and every output block.
module tb_ctr_drbg_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic [1:0]   cmd = 2'b00;
  logic [255:0] seed = '0;
  logic [6:0]   nblk = '0;
  logic         cmd_ready;
  logic         aes_req;
  logic [127:0] aes_key;
  logic [127:0] aes_pt;
  logic         aes_ack = 1'b0;
  logic [127:0] aes_ct = '0;
  logic         rnd_valid;
  logic [127:0] rnd;
  logic         rdy = 1'b1;
  logic         done;
  logic         err;
  logic         inst;
  logic         reseed_req;

  int checks = 0;
  int failures = 0;

  logic         ack_en = 1'b1;
  int           txn = 0;
  int           vcnt = 0;
  logic [127:0] pts[$];
  logic [127:0] rx[$];
  logic [127:0] exp_q[$];

  logic [127:0] m_key = '0;
  logic [127:0] m_v = '0;

  int           lat;
  logic         e;
  logic [127:0] th;
  logic [127:0] tl;
  logic [127:0] held;
  int           t0;
  bit           ok;
  logic [127:0] ones;

  ctr_drbg_core #(
    .SEED_BITS      (256),
    .MAX_BLOCKS     (64),
    .RESEED_INTERVAL(32'd2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid_i   (cmd_valid),
    .cmd_i         (cmd),
    .seed_i        (seed),
    .nblocks_i     (nblk),
    .cmd_ready_o   (cmd_ready),
    .aes_req_o     (aes_req),
    .aes_key_o     (aes_key),
    .aes_pt_o      (aes_pt),
    .aes_ack_i     (aes_ack),
    .aes_ct_i      (aes_ct),
    .rnd_valid_o   (rnd_valid),
    .rnd_o         (rnd),
    .rnd_ready_i   (rdy),
    .done_o        (done),
    .err_o         (err),
    .instantiated_o(inst),
    .reseed_req_o  (reseed_req)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] ecb(input logic [127:0] k, input logic [127:0] p);
    logic [127:0] x;
    x = p ^ k;
    x = {x[114:0], x[127:115]};
    return (x + {k[63:0], k[127:64]}) ^ 128'h5A5A_0F0F_C3C3_9696_1234_5678_9ABC_DEF0;
  endfunction

  // Engine stand-in: acknowledges in the same cycle the request is seen.
  always @(negedge clk) begin
    if (aes_ack) begin
      aes_ack = 1'b0;
    end else if (aes_req && ack_en) begin
      aes_ack = 1'b1;
      aes_ct  = ecb(aes_key, aes_pt);
      pts.push_back(aes_pt);
      txn++;
    end
  end

  always @(negedge clk) begin
    if (rnd_valid) vcnt++;
    if (rnd_valid && rdy) rx.push_back(rnd);
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic m_update(input logic [255:0] pd);
    logic [255:0] t;
    m_v = m_v + 128'd1;
    t[255:128] = ecb(m_key, m_v);
    m_v = m_v + 128'd1;
    t[127:0] = ecb(m_key, m_v);
    t = t ^ pd;
    m_key = t[255:128];
    m_v = t[127:0];
  endtask

  task automatic m_generate(input int n);
    for (int i = 0; i < n; i++) begin
      m_v = m_v + 128'd1;
      exp_q.push_back(ecb(m_key, m_v));
    end
    m_update('0);
  endtask

  task automatic clear_logs();
    rx.delete();
    pts.delete();
    exp_q.delete();
  endtask

  task automatic check_blocks(input string tag);
    chk({tag, "_count"}, 256'(rx.size()), 256'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx.size()) chk({tag, "_blk"}, 256'(rx[i]), 256'(exp_q[i]));
    end
    chk({tag, "_key"}, 256'(aes_key), 256'(m_key));
    chk({tag, "_v"}, 256'(aes_pt), 256'(m_v));
  endtask

  // lat counts rising edges from the accepting edge to the one that samples done_o.
  task automatic run_cmd(input string tag, input logic [1:0] c, input logic [255:0] s,
                         input logic [6:0] n, output int l, output logic er);
    bit seen;
    seen = 1'b0;
    l = 0;
    er = 1'b0;
    cmd_valid = 1'b1;
    cmd = c;
    seed = s;
    nblk = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      if (done) begin
        l = i;
        er = err;
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk({tag, "_done_seen"}, 256'(seen), 256'(1));
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 256'(done), 256'(0));
  endtask

  initial begin
    ones = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", 256'(cmd_ready), 256'(1));
    chk("rst_flags", 256'({aes_req, rnd_valid, done, err, inst, reseed_req}), 256'(0));
    chk("rst_state", {aes_key, aes_pt}, 256'(0));
    chk("rst_rnd", 256'(rnd), 256'(0));

    // Generate without a working state is refused.
    clear_logs();
    vcnt = 0;
    t0 = txn;
    run_cmd("gen_uninst", 2'b11, '0, 7'd1, lat, e);
    chk("gen_uninst_lat", 256'(lat), 256'(1));
    chk("gen_uninst_err", 256'(e), 256'(1));
    chk("gen_uninst_novalid", 256'(vcnt), 256'(0));
    chk("gen_uninst_noaes", 256'(txn), 256'(t0));
    chk("gen_uninst_kv", {aes_key, aes_pt}, 256'(0));

    // Instantiate, then a four-block generate.
    seed = 256'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF_F0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;
    m_key = '0;
    m_v = '0;
    m_update(seed);
    run_cmd("inst", 2'b01, seed, 7'd0, lat, e);
    chk("inst_lat", 256'(lat), 256'(6));
    chk("inst_err", 256'(e), 256'(0));
    chk("inst_flag", 256'(inst), 256'(1));
    chk("inst_key", 256'(aes_key), 256'(m_key));
    chk("inst_v", 256'(aes_pt), 256'(m_v));

    clear_logs();
    m_generate(4);
    run_cmd("gen4", 2'b11, '0, 7'd4, lat, e);
    chk("gen4_lat", 256'(lat), 256'(18));
    chk("gen4_err", 256'(e), 256'(0));
    check_blocks("gen4");
    chk("gen4_rsq", 256'(reseed_req), 256'(0));

    // Back-pressure: the block must hold with no engine traffic until accepted.
    clear_logs();
    m_generate(1);
    rdy = 1'b0;
    cmd_valid = 1'b1;
    cmd = 2'b11;
    nblk = 7'd1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (rnd_valid) break;
      @(posedge clk); #1;
    end
    chk("stall_valid", 256'(rnd_valid), 256'(1));
    held = rnd;
    t0 = txn;
    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (!rnd_valid || rnd !== held || aes_req) ok = 1'b0;
    end
    chk("stall_hold", 256'(ok), 256'(1));
    chk("stall_noreq", 256'(txn), 256'(t0));
    rdy = 1'b1;
    @(posedge clk); #1;
    chk("stall_xfer", 256'({rnd_valid, 32'(rx.size())}), 256'({1'b0, 32'd1}));
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("stall_done", 256'(ok), 256'(1));
    @(posedge clk); #1;
    check_blocks("stall");
    chk("stall_rsq", 256'(reseed_req), 256'(1));

    // Counter past the interval: the third generate is refused.
    run_cmd("gen_rsq", 2'b11, '0, 7'd1, lat, e);
    chk("gen_rsq_err", 256'({lat, e}), 256'({32'd1, 1'b1}));

    seed = 256'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_1357_9BDF_2468_ACE0_0F1E_2D3C;
    m_update(seed);
    run_cmd("reseed", 2'b10, seed, 7'd0, lat, e);
    chk("reseed_lat", 256'({lat, e}), 256'({32'd6, 1'b0}));
    chk("reseed_rsq", 256'(reseed_req), 256'(0));
    chk("reseed_kv", {aes_key, aes_pt}, {m_key, m_v});

    run_cmd("gen_n0", 2'b11, '0, 7'd0, lat, e);
    chk("gen_n0_err", 256'({lat, e}), 256'({32'd1, 1'b1}));
    run_cmd("gen_n65", 2'b11, '0, 7'd65, lat, e);
    chk("gen_n65_err", 256'({lat, e}), 256'({32'd1, 1'b1}));

    clear_logs();
    m_generate(64);
    run_cmd("gen64", 2'b11, '0, 7'd64, lat, e);
    chk("gen64_lat", 256'({lat, e}), 256'({32'd198, 1'b0}));
    check_blocks("gen64");

    // Seed chosen so the instantiated V is all ones; the next plaintext must wrap to zero.
    th = ecb('0, 128'd1);
    tl = ecb('0, 128'd2);
    seed = {th ^ 128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, tl ^ ones};
    m_key = '0;
    m_v = '0;
    m_update(seed);
    run_cmd("wrap_inst", 2'b01, seed, 7'd0, lat, e);
    chk("wrap_v_ones", 256'(aes_pt), 256'(ones));
    clear_logs();
    m_generate(1);
    run_cmd("wrap_gen", 2'b11, '0, 7'd1, lat, e);
    chk("wrap_pt0", 256'(pts.size() > 0 ? pts[0] : ones), 256'(0));
    check_blocks("wrap");

    // Reset while the second Update encryption is outstanding.
    t0 = txn;
    cmd_valid = 1'b1;
    cmd = 2'b01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (txn != t0) break;
      @(posedge clk); #1;
    end
    ack_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (aes_req) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("rst_mid_req", 256'(aes_req), 256'(1));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    chk("rst_mid_idle", 256'({cmd_ready, inst, aes_req}), 256'({1'b1, 1'b0, 1'b0}));
    chk("rst_mid_kv", {aes_key, aes_pt}, 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
